// File: rtl/spdif_pkg.sv
// spdif_pkg: constants, FSM state type and helpers shared by the S/PDIF
// encoder and decoder.
//   PRE_B/PRE_M/PRE_W   preamble half-cell patterns for a prior line level of 0
//   FRAMES_PER_BLOCK    frames per channel-status block
//   SLOTS_PER_SUBFRAME  time slots per subframe (two half-cells each)
//   T*_HALVES           line run lengths in half-cells (short/medium/long)
//   spdif_state_t       encoder FSM state
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    localparam int unsigned FRAMES_PER_BLOCK    = 192;
    localparam int unsigned SLOTS_PER_SUBFRAME  = 32;
    localparam int unsigned HALVES_PER_SUBFRAME = 2 * SLOTS_PER_SUBFRAME;
    localparam int unsigned PRE_HALVES          = 8;
    localparam int unsigned DATA_HALVES         = HALVES_PER_SUBFRAME - PRE_HALVES;

    localparam int unsigned T1_HALVES = 1;
    localparam int unsigned T2_HALVES = 2;
    localparam int unsigned T3_HALVES = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA
    } spdif_state_t;

    // Slots 4..31 of a subframe, bit 0 = slot 4: audio LSB first, V, U=0, C, P.
    // P gives even parity over the 28 slots.
    function automatic logic [27:0] subframe_payload(input logic [23:0] audio,
                                                     input logic        v,
                                                     input logic        c);
        logic p;
        p = ^{c, v, audio};
        return {p, c, 1'b0, v, audio};
    endfunction

    // Line levels of all 64 half-cells, first half-cell in bit 63, assuming a
    // prior line level of 0. Every slot starts with a toggle; a 1 adds a
    // mid-slot toggle. The payload is shifted out rather than indexed.
    function automatic logic [63:0] bmc_cells(input logic [7:0]  pre,
                                              input logic [27:0] payload);
        logic [63:0] cells;
        logic [27:0] rest;
        logic        lvl;
        logic        first;
        cells = {56'b0, pre};
        rest  = payload;
        lvl   = pre[0];
        for (int unsigned s = 0; s < 28; s++) begin
            lvl   = ~lvl;
            first = lvl;
            lvl   = lvl ^ rest[0];
            rest  = rest >> 1;
            cells = {cells[61:0], first, lvl};
        end
        return cells;
    endfunction

endpackage

// File: rtl/spdif_bmc_shifter.sv
// spdif_bmc_shifter: serializes one subframe of precomputed half-cell levels
// onto the line, inverting the whole subframe when the line sat at 1 before it.
//   clk, resetb  clock, synchronous active-low reset
//   load         start a subframe: first half-cell appears next clk
//   step         advance to the next half-cell
//   cells        64 half-cell levels (bit 63 first) for a prior level of 0
//   line         biphase-mark line output
module spdif_bmc_shifter (
    input  logic        clk,
    input  logic        resetb,
    input  logic        load,
    input  logic        step,
    input  logic [63:0] cells,
    output logic        line
);

    logic [62:0] rest;
    logic        prior;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            line  <= 1'b0;
            prior <= 1'b0;
            rest  <= '0;
        end else if (load) begin
            prior <= line;
            line  <= cells[63] ^ line;
            rest  <= cells[62:0];
        end else if (step) begin
            line  <= rest[62] ^ prior;
            rest  <= {rest[61:0], 1'b0};
        end
    end

endmodule

// File: rtl/spdif_encoder.sv
// spdif_encoder: S/PDIF transmitter with a one-pair holding buffer.
//   HALF_DIV      clk cycles per biphase half-cell (2..255)
//   clk, resetb   clock, synchronous active-low reset
//   sample_l/r    24-bit two's complement PCM pair
//   sample_valid  pair presented; transfers when sample_ready is also 1
//   sample_ready  holding buffer empty
//   tx_out        biphase-mark line output
//   frame_start   one-cycle pulse on the first clk of each B preamble
//   underrun      one-cycle pulse when a frame starts with the buffer empty
module spdif_encoder
    import spdif_pkg::*;
#(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic [23:0] sample_l,
    input  logic [23:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        tx_out,
    output logic        frame_start,
    output logic        underrun
);

    spdif_state_t state;
    logic [7:0]   cnt;
    logic [5:0]   hc;
    logic         in_right;
    logic [7:0]   frame;
    logic         buf_full;
    logic [23:0]  buf_l;
    logic [23:0]  buf_r;
    logic [23:0]  cur_r;
    logic         cur_v;

    logic         accept;
    logic         wrap;
    logic         sub_end;
    logic         load;
    logic         step;
    logic         next_left;
    logic [7:0]   frame_nx;
    logic [7:0]   pre;
    logic [23:0]  aud;
    logic         v_bit;
    logic         c_bit;
    logic [63:0]  cells;

    assign sample_ready = ~buf_full;
    assign accept       = sample_valid & ~buf_full;

    always_comb begin
        wrap      = (state != ST_IDLE) && (cnt == 8'(HALF_DIV - 1));
        sub_end   = wrap && (hc == 6'(HALVES_PER_SUBFRAME - 1));
        load      = ((state == ST_IDLE) && buf_full) || sub_end;
        step      = wrap && !sub_end;
        next_left = (state == ST_IDLE) || in_right;

        frame_nx = frame;
        if (state == ST_IDLE)
            frame_nx = '0;
        else if (in_right)
            frame_nx = (frame == 8'(FRAMES_PER_BLOCK - 1)) ? '0 : frame + 8'd1;

        // Left subframes take the buffer directly (zero audio, V=1 if empty);
        // right subframes reuse what was captured at the left load.
        if (next_left) begin
            aud   = buf_full ? buf_l : '0;
            v_bit = ~buf_full;
            pre   = (frame_nx == '0) ? PRE_B : PRE_M;
        end else begin
            aud   = cur_r;
            v_bit = cur_v;
            pre   = PRE_W;
        end
        c_bit = (frame_nx == 8'd2);
        cells = bmc_cells(pre, subframe_payload(aud, v_bit, c_bit));
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hc          <= '0;
            in_right    <= 1'b0;
            frame       <= '0;
            buf_full    <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            cur_r       <= '0;
            cur_v       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (accept) begin
                buf_l <= sample_l;
                buf_r <= sample_r;
            end
            // A pair accepted on the load clk survives the load's emptying.
            buf_full <= accept || (buf_full && !(load && next_left));

            if (load && next_left) begin
                cur_r       <= buf_full ? buf_r : '0;
                cur_v       <= ~buf_full;
                underrun    <= ~buf_full;
                frame_start <= (frame_nx == '0);
            end

            if (load) begin
                state    <= ST_PRE;
                cnt      <= '0;
                hc       <= '0;
                in_right <= ~next_left;
                frame    <= frame_nx;
            end else if (state == ST_IDLE) begin
                cnt <= '0;
                hc  <= '0;
            end else if (wrap) begin
                cnt <= '0;
                hc  <= hc + 6'd1;
                if (hc == 6'(PRE_HALVES - 1))
                    state <= ST_DATA;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    spdif_bmc_shifter u_shifter (
        .clk    (clk),
        .resetb (resetb),
        .load   (load),
        .step   (step),
        .cells  (cells),
        .line   (tx_out)
    );

endmodule
